// File: rtl/axi_pkg.sv
// Shared AXI-subset definitions: response codes, FSM state encodings and ID width.
package axi_pkg;

  localparam int ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// Single-beat AXI3-subset read/write channel bundle between a master and the SRAM slave.
interface axi_sram_slave_if;
  import axi_pkg::*;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [2:0]      awsize;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );

endinterface

// File: rtl/dp_sram_bw.sv
// Simple dual-port byte-writable SRAM: synchronous read, read-before-write on collision.
module dp_sram_bw #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data
);

  // One narrow array per byte lane keeps each lane a single-writer block RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        mem[wr_addr] <= wr_data[gi*8 +: 8];
      end
      if (rd_en) begin
        q_reg <= mem[rd_addr];
      end
    end

    assign rd_data[gi*8 +: 8] = q_reg;
  end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3-subset SRAM responder with independent read and write FSMs.
// Optional out-of-range SLVERR checking is enabled by defining AXI_SRAM_OOR_ERR_EN.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  axi_sram_slave_if.slave  bus
);

  rd_state_t       rd_state_reg;
  logic            arready_reg;
  logic            rvalid_reg;
  logic [ID_W-1:0] rid_reg;
  logic [1:0]      rresp_reg;
  logic            rd_oor_reg;

  wr_state_t       wr_state_reg;
  logic            awready_reg;
  logic            wready_reg;
  logic            bvalid_reg;
  logic [ID_W-1:0] bid_reg;
  logic [1:0]      bresp_reg;
  logic            wr_oor_reg;
  logic [AW-1:0]   wr_idx_reg;

  logic            ar_fire;
  logic            aw_fire;
  logic            w_fire;
  logic            ar_oor;
  logic            aw_oor;
  logic            sram_we;
  logic [31:0]     sram_q;

`ifdef AXI_SRAM_OOR_ERR_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH) << 2;
  assign ar_oor = (bus.araddr >= ADDR_LIMIT);
  assign aw_oor = (bus.awaddr >= ADDR_LIMIT);
`else
  assign ar_oor = 1'b0;
  assign aw_oor = 1'b0;
`endif

  assign ar_fire = (rd_state_reg == R_IDLE) && arready_reg && bus.arvalid;
  assign aw_fire = (wr_state_reg == W_IDLE) && awready_reg && bus.awvalid;
  assign w_fire  = (wr_state_reg == W_DATA) && wready_reg && bus.wvalid;
  // Out-of-range writes still complete the handshake but never touch the array.
  assign sram_we = resetn && w_fire && !wr_oor_reg;

  dp_sram_bw #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .rd_en   (ar_fire),
    .rd_addr (bus.araddr[AW+1:2]),
    .rd_data (sram_q),
    .wr_en   (sram_we),
    .wr_addr (wr_idx_reg),
    .wr_be   (bus.wstrb),
    .wr_data (bus.wdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rid_reg      <= '0;
      rresp_reg    <= RESP_OKAY;
      rd_oor_reg   <= 1'b0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (ar_fire) begin
            rid_reg      <= bus.arid;
            rresp_reg    <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            rd_oor_reg   <= ar_oor;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b1;
            rd_state_reg <= R_RESP;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_reg   <= 1'b0;
            arready_reg  <= 1'b1;
            rd_state_reg <= R_IDLE;
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_reg <= W_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bid_reg      <= '0;
      bresp_reg    <= RESP_OKAY;
      wr_oor_reg   <= 1'b0;
      wr_idx_reg   <= '0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          awready_reg <= 1'b1;
          if (aw_fire) begin
            bid_reg      <= bus.awid;
            bresp_reg    <= aw_oor ? RESP_SLVERR : RESP_OKAY;
            wr_oor_reg   <= aw_oor;
            wr_idx_reg   <= bus.awaddr[AW+1:2];
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b1;
            wr_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b1;
            wr_state_reg <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            wr_state_reg <= W_IDLE;
          end
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  assign bus.arready = arready_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rid     = rid_reg;
  assign bus.rresp   = rresp_reg;
  assign bus.rlast   = 1'b1;
  // RAM output register holds across rready stalls; masked to zero when idle or out of range.
  assign bus.rdata   = (rvalid_reg && !rd_oor_reg) ? sram_q : 32'h0;
  assign bus.awready = awready_reg;
  assign bus.wready  = wready_reg;
  assign bus.bvalid  = bvalid_reg;
  assign bus.bid     = bid_reg;
  assign bus.bresp   = bresp_reg;

  logic unused_ok;
  assign unused_ok = ^{bus.arlen, bus.awsize, bus.araddr, bus.awaddr};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave; OOR cases follow AXI_SRAM_OOR_ERR_EN.
module tb_axi_sram_slave;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_sram_slave_if bus ();

  axi_sram_slave #(
    .DEPTH (4096)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [3:0] id, output logic [1:0] resp, output logic [3:0] id_o);
    int n = 0;
    bus.awaddr  = addr;
    bus.awid    = id;
    bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("aw_ready_wait", bus.awready, 1);
    tick();
    bus.awvalid = 1'b0;
    check("wready_after_aw", bus.wready, 1);
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("bvalid_after_w", bus.bvalid, 1);
    resp = bus.bresp;
    id_o = bus.bid;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("bvalid_drop", bus.bvalid, 0);
    $display("WR addr=%h data=%h strb=%h id=%0d -> bid=%0d bresp=%0d", addr, data, strb, id, id_o, resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                          output logic [31:0] data, output logic [1:0] resp, output logic [3:0] id_o);
    int n = 0;
    bus.araddr  = addr;
    bus.arid    = id;
    bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ar_ready_wait", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    check("rvalid_after_ar", bus.rvalid, 1);
    check("rlast", bus.rlast, 1);
    data = bus.rdata;
    resp = bus.rresp;
    id_o = bus.rid;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("rvalid_drop", bus.rvalid, 0);
    check("arready_back", bus.arready, 1);
    $display("RD addr=%h id=%0d -> rid=%0d rdata=%h rresp=%0d", addr, id, id_o, data, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [3:0]  i;
    logic [31:0] held_data;

    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awsize = 3'd2; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;

    // Reset values
    resetn = 1'b0;
    repeat (3) tick();
    check("rst_arready", bus.arready, 0);
    check("rst_awready", bus.awready, 0);
    check("rst_wready",  bus.wready, 0);
    check("rst_rvalid",  bus.rvalid, 0);
    check("rst_bvalid",  bus.bvalid, 0);
    check("rst_rid",     bus.rid, 0);
    check("rst_bid",     bus.bid, 0);
    check("rst_rdata",   bus.rdata, 0);
    check("rst_rresp",   bus.rresp, 0);
    check("rst_bresp",   bus.bresp, 0);
    resetn = 1'b1;
    tick();
    check("post_rst_arready", bus.arready, 1);
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_wready",  bus.wready, 0);
    $display("RESET released");

    // W before AW is not accepted
    bus.wvalid = 1'b1;
    bus.wdata  = 32'hFFFF_FFFF;
    bus.wstrb  = 4'hF;
    tick();
    check("early_w_wready", bus.wready, 0);
    check("early_w_bvalid", bus.bvalid, 0);
    bus.wvalid = 1'b0;

    // Write then read
    axi_write(32'h100, 32'hDEAD_BEEF, 4'hF, 4'd2, r, i);
    check("wr100_bresp", r, 2'b00);
    check("wr100_bid", i, 4'd2);
    axi_read(32'h100, 4'd1, d, r, i);
    check("rd100_rid", i, 4'd1);
    check("rd100_rdata", d, 32'hDEAD_BEEF);
    check("rd100_rresp", r, 2'b00);

    // Partial write and zero-strobe write
    axi_write(32'h20, 32'h1122_3344, 4'hF, 4'd3, r, i);
    axi_write(32'h20, 32'hAABB_CCDD, 4'b0100, 4'd4, r, i);
    check("partial_bid", i, 4'd4);
    axi_read(32'h20, 4'd5, d, r, i);
    check("partial_rdata", d, 32'h11BB_3344);
    axi_write(32'h20, 32'hFFFF_FFFF, 4'b0000, 4'd6, r, i);
    axi_read(32'h20, 4'd6, d, r, i);
    check("strb0_rdata", d, 32'h11BB_3344);

    // Backpressure on R
    bus.araddr  = 32'h100;
    bus.arid    = 4'd7;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    held_data = bus.rdata;
    check("bp_first_rdata", held_data, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_rvalid", bus.rvalid, 1);
      check("bp_rdata", bus.rdata, 32'hDEAD_BEEF);
      check("bp_rid", bus.rid, 4'd7);
      check("bp_arready", bus.arready, 0);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("bp_arready_after", bus.arready, 1);
    check("bp_rvalid_after", bus.rvalid, 0);
    $display("RD backpressure addr=00000100 rid=7 rdata=%h", held_data);

    // Same-cycle read and write commit to one word
    axi_write(32'h40, 32'h0, 4'hF, 4'd1, r, i);
    bus.awaddr  = 32'h40;
    bus.awid    = 4'd8;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("col_wready", bus.wready, 1);
    bus.wdata   = 32'h5;
    bus.wstrb   = 4'hF;
    bus.wvalid  = 1'b1;
    bus.araddr  = 32'h40;
    bus.arid    = 4'd9;
    bus.arvalid = 1'b1;
    tick();
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    check("col_rvalid", bus.rvalid, 1);
    check("col_bvalid", bus.bvalid, 1);
    check("col_rdata_old", bus.rdata, 32'h0);
    check("col_rid", bus.rid, 4'd9);
    bus.rready = 1'b1;
    bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    $display("COLLISION addr=00000040 read old, write 00000005");
    axi_read(32'h40, 4'd10, d, r, i);
    check("col_rdata_new", d, 32'h5);

    // Out-of-range behaviour
    axi_write(32'h0, 32'h1234_5678, 4'hF, 4'd1, r, i);
    axi_write(32'h4000, 32'hCAFE_F00D, 4'hF, 4'd11, r, i);
    check("oor_bid", i, 4'd11);
`ifdef AXI_SRAM_OOR_ERR_EN
    check("oor_bresp", r, 2'b10);
    axi_read(32'h0, 4'd2, d, r, i);
    check("oor_word0_kept", d, 32'h1234_5678);
    axi_read(32'h4000, 4'd12, d, r, i);
    check("oor_rresp", r, 2'b10);
    check("oor_rdata", d, 32'h0);
`else
    check("alias_bresp", r, 2'b00);
    axi_read(32'h0, 4'd2, d, r, i);
    check("alias_word0", d, 32'hCAFE_F00D);
    check("alias_rresp", r, 2'b00);
`endif

    // Reset while a read response is pending
    bus.araddr  = 32'h20;
    bus.arid    = 4'd13;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("rstmid_rvalid_before", bus.rvalid, 1);
    resetn = 1'b0;
    tick();
    check("rstmid_rvalid", bus.rvalid, 0);
    check("rstmid_rid", bus.rid, 0);
    resetn = 1'b1;
    tick();
    check("rstmid_arready", bus.arready, 1);
    check("rstmid_rvalid_after", bus.rvalid, 0);
    $display("RESET mid-read addr=00000020 abandoned");
    axi_read(32'h20, 4'd14, d, r, i);
    check("rstmid_mem_kept", d, 32'h11BB_3344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
